// File: rtl/keccak_pkg.sv
// Shared Keccak definitions: lane geometry, FSM state type and chi row functions.
package keccak_pkg;

  localparam int KECCAK_LANES  = 25;
  localparam int KECCAK_ROW    = 5;
  localparam int KECCAK_LANE_W = 64;

  typedef logic [KECCAK_LANE_W-1:0] lane_t;
  typedef lane_t [KECCAK_ROW-1:0] row_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } chi_state_e;

  function automatic int lane_idx(input int x, input int y);
    return KECCAK_ROW * y + x;
  endfunction

  function automatic row_t chi_row(input row_t a);
    row_t b;
    for (int x = 0; x < KECCAK_ROW; x++)
      b[x] = a[x] ^ (~a[(x+1)%5] & a[(x+2)%5]);
    return b;
  endfunction

  function automatic row_t chi_inv_row(input row_t b);
    row_t a;
    for (int x = 0; x < KECCAK_ROW; x++)
      a[x] = b[x] ^ (~b[(x+1)%5] & (b[(x+2)%5] ^ (~b[(x+3)%5] & b[(x+4)%5])));
    return a;
  endfunction

endpackage

// File: rtl/keccak_chi_inv_row.sv
// Combinational inverse chi for one 5-lane plane; lane x at row_i[LANE_W*x +: LANE_W].
module keccak_chi_inv_row
  import keccak_pkg::*;
#(
  parameter int LANE_W = 64
) (
  input  logic [KECCAK_ROW*LANE_W-1:0] row_i,
  output logic [KECCAK_ROW*LANE_W-1:0] row_o
);

  logic [KECCAK_ROW-1:0][LANE_W-1:0] b;

  for (genvar x = 0; x < KECCAK_ROW; x++) begin : g_lane
    assign b[x] = row_i[LANE_W*x +: LANE_W];
    assign row_o[LANE_W*x +: LANE_W] =
      b[x] ^ (~b[(x+1)%5] & (b[(x+2)%5] ^ (~b[(x+3)%5] & b[(x+4)%5])));
  end

endmodule

// File: rtl/keccak_chi_inv_iter.sv
// Iterative inverse chi over a full Keccak state, ROWS_PER_CYCLE planes per cycle.
// Optional round-trip self-check enabled by CHI_INV_ROUNDTRIP_CHECK_EN (adds chk_err).
//   state   | meaning
//   IDLE    | waiting for an input state, in_ready high
//   RUN     | inverting planes cnt..cnt+ROWS_PER_CYCLE-1 into the result register
//   DONE    | result presented on out_state with out_valid high
module keccak_chi_inv_iter
  import keccak_pkg::*;
#(
  parameter int LANE_W         = 64,
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [KECCAK_LANES*LANE_W-1:0] in_state,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [KECCAK_LANES*LANE_W-1:0] out_state,
  output logic                           busy
`ifdef CHI_INV_ROUNDTRIP_CHECK_EN
  ,
  output logic                           chk_err
`endif
);

  localparam int STATE_W = KECCAK_LANES * LANE_W;
  localparam int PLANE_W = KECCAK_ROW * LANE_W;
  localparam logic [2:0] LAST_CNT = 3'(KECCAK_ROW - ROWS_PER_CYCLE);
  localparam logic [2:0] STEP     = 3'(ROWS_PER_CYCLE);

  if (ROWS_PER_CYCLE != 1 && ROWS_PER_CYCLE != 5) begin : g_bad_rpc
    $error("keccak_chi_inv_iter: ROWS_PER_CYCLE must be 1 or 5");
  end

  chi_state_e         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [STATE_W-1:0] src_q, src_d;
  logic [STATE_W-1:0] res_q, res_d;
  logic [STATE_W-1:0] out_q, out_d;

  logic [ROWS_PER_CYCLE-1:0][2:0]         plane;
  logic [ROWS_PER_CYCLE-1:0][PLANE_W-1:0] row_src;
  logic [ROWS_PER_CYCLE-1:0][PLANE_W-1:0] row_inv;

  for (genvar i = 0; i < ROWS_PER_CYCLE; i++) begin : g_row
    assign plane[i]   = cnt_q + 3'(i);
    assign row_src[i] = src_q[PLANE_W*int'(plane[i]) +: PLANE_W];
    keccak_chi_inv_row #(.LANE_W(LANE_W)) u_row (
      .row_i (row_src[i]),
      .row_o (row_inv[i])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    res_d   = res_q;
    out_d   = out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          src_d   = in_state;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < ROWS_PER_CYCLE; i++)
          res_d[PLANE_W*int'(plane[i]) +: PLANE_W] = row_inv[i];
        // out_state only moves on the edge into DONE, so it is loaded from the completed result here
        if (cnt_q == LAST_CNT) begin
          out_d   = res_d;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + STEP;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      res_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      res_q   <= res_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_state = out_q;

  a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt_q < 3'd5);

`ifdef CHI_INV_ROUNDTRIP_CHECK_EN
  if (LANE_W > KECCAK_LANE_W) begin : g_bad_lane_w
    $error("keccak_chi_inv_iter: round-trip check supports LANE_W <= 64");
  end

  logic mism;

  // Lanes are zero-extended into lane_t; chi is bitwise so the upper bits stay zero.
  always_comb begin
    row_t a_row;
    row_t b_row;
    mism  = 1'b0;
    a_row = '0;
    b_row = '0;
    for (int y = 0; y < KECCAK_ROW; y++) begin
      for (int x = 0; x < KECCAK_ROW; x++)
        a_row[x] = lane_t'(out_q[LANE_W*lane_idx(x, y) +: LANE_W]);
      b_row = chi_row(a_row);
      for (int x = 0; x < KECCAK_ROW; x++)
        if (b_row[x][LANE_W-1:0] != src_q[LANE_W*lane_idx(x, y) +: LANE_W]) mism = 1'b1;
    end
  end

  assign chk_err = (state_q == ST_DONE) && mism;
`endif

endmodule
